// File: rtl/gps_cfg_sequencer_if.sv
// Request/active configuration bundle shared by the register bank, the config
// sequencer and the C/A-code / NCO signal-generator datapath.
interface gps_cfg_sequencer_if;
  logic        enable_in;
  logic [4:0]  n_sat_in;
  logic        use_preset_in;
  logic        use_msg_preset_in;
  logic        noise_off_in;
  logic        signal_off_in;
  logic        ca_phase_start_in;
  logic [15:0] ca_phase_in;
  logic [7:0]  doppler_in;
  logic [7:0]  snr_in;
  logic        code_phase_done;

  logic        gen_enable_out;
  logic        ca_load_out;
  logic [4:0]  n_sat_out;
  logic        use_preset_out;
  logic        use_msg_preset_out;
  logic        noise_off_out;
  logic        signal_off_out;
  logic [15:0] ca_phase_out;
  logic [7:0]  doppler_out;
  logic [7:0]  snr_out;
  logic [4:0]  epoch_cnt_out;
  logic        bit_strobe_out;
  logic        cfg_pending_out;
  logic        epoch_timeout_out;

  modport master (
    output enable_in, n_sat_in, use_preset_in, use_msg_preset_in, noise_off_in,
           signal_off_in, ca_phase_start_in, ca_phase_in, doppler_in, snr_in,
           code_phase_done,
    input  gen_enable_out, ca_load_out, n_sat_out, use_preset_out, use_msg_preset_out,
           noise_off_out, signal_off_out, ca_phase_out, doppler_out, snr_out,
           epoch_cnt_out, bit_strobe_out, cfg_pending_out, epoch_timeout_out
  );

  modport slave (
    input  enable_in, n_sat_in, use_preset_in, use_msg_preset_in, noise_off_in,
           signal_off_in, ca_phase_start_in, ca_phase_in, doppler_in, snr_in,
           code_phase_done,
    output gen_enable_out, ca_load_out, n_sat_out, use_preset_out, use_msg_preset_out,
           noise_off_out, signal_off_out, ca_phase_out, doppler_out, snr_out,
           epoch_cnt_out, bit_strobe_out, cfg_pending_out, epoch_timeout_out
  );
endinterface

// File: rtl/gps_cfg_sequencer.sv
// Turns free-running register-bank outputs into a glitch-free active GPS generator
// configuration. Optional stall watchdog enabled by defining GPS_CFG_SEQ_TIMEOUT_EN.
module gps_cfg_sequencer #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int EPOCH_TIMEOUT  = 32768,
  parameter int EPOCHS_PER_BIT = 20
) (
  input  logic               clk_in,
  input  logic               rst_in_n,
  gps_cfg_sequencer_if.slave cfg
);

  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [4:0] EPOCH_LAST = 5'(EPOCHS_PER_BIT - 1);

  typedef enum logic [1:0] {
    ST_OFF,
    ST_LOAD,
    ST_SETTLE,
    ST_RUN
  } state_t;

  state_t              state;
  logic [SETTLE_W-1:0] settle_cnt;
  logic                reload_req;
  logic                ca_start_q;

  logic ca_start_rise;
  logic hard_change;
  logic epoch_in_run;
  logic timeout_fire;
  logic enter_load;
  logic cfg_differs;

  assign ca_start_rise = cfg.ca_phase_start_in & ~ca_start_q;

  assign hard_change = (cfg.n_sat_in != cfg.n_sat_out)
                    || (cfg.use_preset_in != cfg.use_preset_out)
                    || ca_start_rise;

  assign epoch_in_run = (state == ST_RUN) && cfg.code_phase_done;

  // A reload pending at an epoch, or one arriving with it, restarts the datapath there.
  assign enter_load = cfg.enable_in
                   && ((state == ST_OFF)
                    || (epoch_in_run && (reload_req || hard_change))
                    || timeout_fire);

  assign cfg_differs = (cfg.n_sat_in != cfg.n_sat_out)
                    || (cfg.use_preset_in != cfg.use_preset_out)
                    || (cfg.use_msg_preset_in != cfg.use_msg_preset_out)
                    || (cfg.noise_off_in != cfg.noise_off_out)
                    || (cfg.signal_off_in != cfg.signal_off_out)
                    || (cfg.ca_phase_in != cfg.ca_phase_out)
                    || (cfg.doppler_in != cfg.doppler_out)
                    || (cfg.snr_in != cfg.snr_out);

`ifdef GPS_CFG_SEQ_TIMEOUT_EN
  localparam int TIMEOUT_W = $clog2(EPOCH_TIMEOUT + 1);
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(EPOCH_TIMEOUT - 1);

  logic [TIMEOUT_W-1:0] timeout_cnt;
  logic                 timeout_q;

  assign timeout_fire = (state == ST_RUN) && !cfg.code_phase_done
                     && (timeout_cnt == TIMEOUT_LAST);
  assign cfg.epoch_timeout_out = timeout_q;

  // Counts RUN cycles since the last epoch; zero whenever outside RUN.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      timeout_cnt <= '0;
      timeout_q   <= 1'b0;
    end else begin
      if ((state == ST_RUN) && !cfg.code_phase_done && !timeout_fire) begin
        timeout_cnt <= timeout_cnt + 1'b1;
      end else begin
        timeout_cnt <= '0;
      end

      if (!cfg.enable_in) begin
        timeout_q <= 1'b0;
      end else if (timeout_fire) begin
        timeout_q <= 1'b1;
      end
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg     = (EPOCH_TIMEOUT != 0);
  assign timeout_fire           = 1'b0;
  assign cfg.epoch_timeout_out  = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state                  <= ST_OFF;
      settle_cnt             <= '0;
      reload_req             <= 1'b0;
      ca_start_q             <= 1'b0;
      cfg.gen_enable_out     <= 1'b0;
      cfg.ca_load_out        <= 1'b0;
      cfg.n_sat_out          <= '0;
      cfg.use_preset_out     <= 1'b0;
      cfg.use_msg_preset_out <= 1'b0;
      cfg.noise_off_out      <= 1'b0;
      cfg.signal_off_out     <= 1'b0;
      cfg.ca_phase_out       <= '0;
      cfg.doppler_out        <= '0;
      cfg.snr_out            <= '0;
      cfg.epoch_cnt_out      <= '0;
      cfg.bit_strobe_out     <= 1'b0;
      cfg.cfg_pending_out    <= 1'b0;
    end else begin
      ca_start_q          <= cfg.ca_phase_start_in;
      cfg.cfg_pending_out <= cfg_differs;
      cfg.ca_load_out     <= 1'b0;
      cfg.bit_strobe_out  <= 1'b0;

      if (hard_change) begin
        reload_req <= 1'b1;
      end

      // Enable drop outranks everything; active registers keep their values.
      if (!cfg.enable_in) begin
        state              <= ST_OFF;
        cfg.gen_enable_out <= 1'b0;
        reload_req         <= 1'b0;
      end else if (enter_load) begin
        state                  <= ST_LOAD;
        cfg.gen_enable_out     <= 1'b0;
        cfg.ca_load_out        <= 1'b1;
        cfg.n_sat_out          <= cfg.n_sat_in;
        cfg.use_preset_out     <= cfg.use_preset_in;
        cfg.use_msg_preset_out <= cfg.use_msg_preset_in;
        cfg.noise_off_out      <= cfg.noise_off_in;
        cfg.signal_off_out     <= cfg.signal_off_in;
        cfg.ca_phase_out       <= cfg.ca_phase_in;
        cfg.doppler_out        <= cfg.doppler_in;
        cfg.snr_out            <= cfg.snr_in;
        cfg.epoch_cnt_out      <= '0;
        reload_req             <= 1'b0;
      end else begin
        case (state)
          ST_LOAD: begin
            state      <= ST_SETTLE;
            settle_cnt <= '0;
          end
          ST_SETTLE: begin
            if (settle_cnt == SETTLE_LAST) begin
              state              <= ST_RUN;
              cfg.gen_enable_out <= 1'b1;
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
          ST_RUN: begin
            if (cfg.code_phase_done) begin
              cfg.use_msg_preset_out <= cfg.use_msg_preset_in;
              cfg.noise_off_out      <= cfg.noise_off_in;
              cfg.signal_off_out     <= cfg.signal_off_in;
              cfg.doppler_out        <= cfg.doppler_in;
              cfg.snr_out            <= cfg.snr_in;
              cfg.bit_strobe_out     <= (cfg.epoch_cnt_out == EPOCH_LAST);
              cfg.epoch_cnt_out      <= (cfg.epoch_cnt_out == EPOCH_LAST)
                                        ? 5'd0 : cfg.epoch_cnt_out + 5'd1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule
